// File: rtl/seq_mul16_pkg.sv
// Shared CPU multiplier definitions: operand/product widths and FSM state encoding.
package seq_mul16_pkg;

  localparam int MUL_W  = 16;
  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mul16_adder.sv
// Kogge-Stone prefix adder, purely combinational; cin folds into bit 0 generate.
module adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic         cout,
  output logic [W-1:0] sum
);

  localparam int L = $clog2(W);

  logic [L:0][W-1:0] gen;
  logic [L:0][W-1:0] prp;

  always_comb begin
    gen = '0;
    prp = '0;
    gen[0] = x & y;
    prp[0] = x ^ y;
    gen[0][0] = gen[0][0] | (prp[0][0] & cin);
    for (int s = 0; s < L; s++) begin
      for (int i = 0; i < W; i++) begin
        if (i >= (1 << s)) begin
          gen[s+1][i] = gen[s][i] | (prp[s][i] & gen[s][i-(1<<s)]);
          prp[s+1][i] = prp[s][i] & prp[s][i-(1<<s)];
        end else begin
          gen[s+1][i] = gen[s][i];
          prp[s+1][i] = prp[s][i];
        end
      end
    end
  end

  // gen[L][i] is the carry out of bit i including cin
  assign sum  = prp[0] ^ {gen[L][W-2:0], cin};
  assign cout = gen[L][W-1];

endmodule

// File: rtl/seq_mul16.sv
// Radix-2 shift-add 16x16 unsigned multiplier; out_valid 17 cycles after accept.
// Result held in DONE until out_ready; in_ready low while running or holding.
module seq_mul16
  import seq_mul16_pkg::*;
#(
  parameter int WIDTH = MUL_W,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] add_y;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  assign add_y = acc_lo_q[0] ? mcand_q : '0;

  adder #(.W(WIDTH)) u_adder (
    .x    (acc_hi_q),
    .y    (add_y),
    .cin  (1'b0),
    .cout (add_cout),
    .sum  (add_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_W'(WIDTH-1)) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q == ST_RUN);
    out_valid = (state_q == ST_DONE);
    product   = {acc_hi_q, acc_lo_q};
  end

  always_comb begin
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    if (state_q == ST_IDLE && in_valid) begin
      mcand_d  = a;
      acc_lo_d = b;
      acc_hi_d = '0;
      cnt_d    = '0;
    end else if (state_q == ST_RUN) begin
      // keep the full 17-bit sum: cout becomes the new top bit
      {acc_hi_d, acc_lo_d} = {add_cout, add_sum, acc_lo_q[WIDTH-1:1]};
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
